// File: rtl/if_stage_pkg.sv
// if_stage shared types and constants.
// Exception codes, NOP encoding, meta and packet bundles.
package if_stage_pkg;

  localparam logic [6:0]  EXP_NONE = 7'h00;
  localparam logic [6:0]  EXP_ADEF = 7'h08;
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fij;
    logic        u0;
    logic        u1;
  } meta_t;

  typedef struct packed {
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fij;
    logic        u0;
    logic        u1;
    logic [6:0]  exc;
  } pkt_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one aligned 8-byte i-cache request
// in flight, registered two-instruction packet out to decode.
// Ports: clk/rst, flush/set_pc redirects, full throttle, bpu_* predictor
// lookup, icache_* request/response, packet outputs (input_valid ...).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        set_pc,
  input  logic [31:0] set_pc_target,
  input  logic        full,
  output logic [31:0] bpu_pc,
  input  logic [31:0] bpu_pc_next,
  input  logic        bpu_first_inst_jmp,
  input  logic        bpu_unknown0,
  input  logic        bpu_unknown1,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_addr_ok,
  input  logic        icache_data_valid,
  input  logic [63:0] icache_rdata,
  input  logic [6:0]  icache_exception,
  output logic        input_valid,
  output logic [31:0] inst0,
  output logic [31:0] inst1,
  output logic [31:0] pc_out,
  output logic [31:0] pc_next_out,
  output logic        first_inst_jmp,
  output logic        unknown0,
  output logic        unknown1,
  output logic [6:0]  exception_out
);

  typedef enum logic [1:0] {
    IF_RUN  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2,
    IF_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  meta_t       meta_q, meta_d;
  pkt_t        pkt_q, pkt_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redir_pc;
  logic        pc_ok;
  logic        can_issue;
  logic        resp_ok;
  logic        req;
  logic        accept;

  always_comb begin
    // set_pc is ignored in HOLD: only flush may leave it
    redirect  = flush |
                (set_pc & valid_q & (state_q != IF_HOLD));
    redir_pc  = flush ? flush_target : set_pc_target;
    pc_ok     = (pc_q[1:0] == 2'b00);
    can_issue = ~rst & ~full & ~redirect & pc_ok;
    resp_ok   = icache_data_valid &
                (icache_exception == EXP_NONE);

    req = 1'b0;
    unique case (state_q)
      IF_RUN:  req = can_issue;
      IF_WAIT: req = can_issue & resp_ok;
      IF_DROP: req = can_issue & icache_data_valid;
      IF_HOLD: req = 1'b0;
    endcase
    accept = req & icache_addr_ok;

    state_d = state_q;
    pc_d    = pc_q;
    meta_d  = meta_q;
    pkt_d   = pkt_q;
    valid_d = 1'b0;

    if (accept) begin
      meta_d = '{pc:      pc_q,
                 pc_next: bpu_pc_next,
                 fij:     bpu_first_inst_jmp,
                 u0:      bpu_unknown0,
                 u1:      bpu_unknown1};
      pc_d   = bpu_pc_next;
    end
    if (redirect) pc_d = redir_pc;

    unique case (state_q)
      IF_RUN: begin
        if (redirect) begin
          state_d = IF_RUN;
        end else if (accept) begin
          state_d = IF_WAIT;
        end else if (~pc_ok & ~full) begin
          state_d = IF_HOLD;
          valid_d = 1'b1;
          pkt_d   = '{inst0:   INST_NOP,
                      inst1:   INST_NOP,
                      pc:      pc_q,
                      pc_next: pc_q + 32'd4,
                      fij:     1'b0,
                      u0:      1'b0,
                      u1:      1'b0,
                      exc:     EXP_ADEF};
        end
      end
      IF_WAIT: begin
        if (redirect) begin
          // a response landing with the redirect retires the request
          state_d = icache_data_valid ? IF_RUN : IF_DROP;
        end else if (icache_data_valid) begin
          valid_d = 1'b1;
          pkt_d   = '{inst0:   resp_ok ? icache_rdata[31:0]
                                       : INST_NOP,
                      inst1:   resp_ok ? icache_rdata[63:32]
                                       : INST_NOP,
                      pc:      meta_q.pc,
                      pc_next: meta_q.pc_next,
                      fij:     meta_q.fij,
                      u0:      meta_q.u0,
                      u1:      meta_q.u1,
                      exc:     icache_exception};
          if (!resp_ok)    state_d = IF_HOLD;
          else if (accept) state_d = IF_WAIT;
          else             state_d = IF_RUN;
        end
      end
      IF_DROP: begin
        if (icache_data_valid)
          state_d = accept ? IF_WAIT : IF_RUN;
      end
      IF_HOLD: begin
        if (flush) state_d = IF_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IF_RUN;
      pc_q    <= RESET_PC;
      meta_q  <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      meta_q  <= meta_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
    end
  end

  assign bpu_pc         = pc_q;
  assign icache_req     = req;
  assign icache_addr    = {pc_q[31:3], 3'b000};
  assign input_valid    = valid_q;
  assign inst0          = pkt_q.inst0;
  assign inst1          = pkt_q.inst1;
  assign pc_out         = pkt_q.pc;
  assign pc_next_out    = pkt_q.pc_next;
  assign first_inst_jmp = pkt_q.fij;
  assign unknown0       = pkt_q.u0;
  assign unknown1       = pkt_q.u1;
  assign exception_out  = pkt_q.exc;

endmodule

// File: tb/tb_if_stage.sv
// if_stage bench: i-cache and predictor models, packet scoreboard,
// table of straight-line fetch runs plus redirect/full/exception cases.
module tb_if_stage;

  localparam logic [6:0]  ADEF = 7'h08;
  localparam logic [6:0]  IEXC = 7'h03;
  localparam logic [31:0] NOP  = 32'h0340_0000;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic [31:0] flush_target = 0;
  logic        set_pc = 0;
  logic [31:0] set_pc_target = 0;
  logic        full = 0;
  logic [31:0] bpu_pc;
  logic [31:0] bpu_pc_next;
  logic        bpu_first_inst_jmp, bpu_unknown0, bpu_unknown1;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_valid;
  logic [63:0] icache_rdata;
  logic [6:0]  icache_exception;
  logic        input_valid;
  logic [31:0] inst0, inst1, pc_out, pc_next_out;
  logic        first_inst_jmp, unknown0, unknown1;
  logic [6:0]  exception_out;

  if_stage dut (
    .clk(clk), .rst(rst),
    .flush(flush), .flush_target(flush_target),
    .set_pc(set_pc), .set_pc_target(set_pc_target),
    .full(full),
    .bpu_pc(bpu_pc), .bpu_pc_next(bpu_pc_next),
    .bpu_first_inst_jmp(bpu_first_inst_jmp),
    .bpu_unknown0(bpu_unknown0), .bpu_unknown1(bpu_unknown1),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_addr_ok(icache_addr_ok),
    .icache_data_valid(icache_data_valid),
    .icache_rdata(icache_rdata),
    .icache_exception(icache_exception),
    .input_valid(input_valid),
    .inst0(inst0), .inst1(inst1),
    .pc_out(pc_out), .pc_next_out(pc_next_out),
    .first_inst_jmp(first_inst_jmp),
    .unknown0(unknown0), .unknown1(unknown1),
    .exception_out(exception_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        fij;
    logic        u0;
    logic        u1;
    logic [6:0]  exc;
  } tpkt_t;

  typedef struct {
    logic [31:0] start;
    int          lat;
    int          n;
    logic [31:0] first_next;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int fcyc = 0;
  bit strict = 0;
  tpkt_t exp_q[$];
  int times[$];
  logic [31:0] acc_q[$];
  logic [31:0] jmp_src = 32'hffff_ffff;
  logic [31:0] jmp_dst = 32'h0;
  logic [31:0] exc_addr = 32'hffff_ffff;

  function automatic logic [31:0] iw(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  function automatic tpkt_t mk(input logic [31:0] pc,
                               input logic [31:0] nxt,
                               input logic fij);
    logic [31:0] a;
    a = {pc[31:3], 3'b000};
    mk = '{pc: pc, nxt: nxt, i0: iw(a), i1: iw(a + 32'd4),
           fij: fij, u0: pc[3], u1: pc[4], exc: 7'h0};
  endfunction

  // predictor model
  always_comb begin
    bpu_first_inst_jmp = (bpu_pc == jmp_src);
    bpu_pc_next = bpu_first_inst_jmp ? jmp_dst
                : {bpu_pc[31:3], 3'b000} + 32'd8;
    bpu_unknown0 = bpu_pc[3];
    bpu_unknown1 = bpu_pc[4];
  end

  // i-cache model: always accepts, answers after lat cycles
  logic        pend_v = 0;
  logic [31:0] pend_addr = 0;
  int          pend_due = 0;

  assign icache_addr_ok    = 1'b1;
  assign icache_data_valid = pend_v && (cyc >= pend_due);
  assign icache_rdata      = {iw(pend_addr + 32'd4), iw(pend_addr)};
  assign icache_exception  = (icache_data_valid && pend_addr == exc_addr)
                             ? IEXC : 7'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend_v <= 0;
    end else if (icache_req && icache_addr_ok) begin
      n_chk++;
      if (pend_v && !icache_data_valid) begin
        n_fail++;
        $display("FAIL double_req: addr %h while %h outstanding",
                 icache_addr, pend_addr);
      end
      acc_q.push_back(icache_addr);
      pend_v    <= 1;
      pend_addr <= icache_addr;
      pend_due  <= cyc + lat;
    end else if (icache_data_valid) begin
      pend_v <= 0;
    end
  end

  // packet scoreboard
  tpkt_t mon_got, mon_exp;
  always @(negedge clk) begin
    if (strict && input_valid) begin
      mon_got = '{pc: pc_out, nxt: pc_next_out, i0: inst0, i1: inst1,
                  fij: first_inst_jmp, u0: unknown0, u1: unknown1,
                  exc: exception_out};
      n_chk++;
      times.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pkt: pc %h nxt %h", pc_out, pc_next_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL pkt: got pc=%h nxt=%h i0=%h i1=%h a=%b%b%b exc=%h required pc=%h nxt=%h i0=%h i1=%h a=%b%b%b exc=%h",
                   mon_got.pc, mon_got.nxt, mon_got.i0, mon_got.i1,
                   mon_got.fij, mon_got.u0, mon_got.u1, mon_got.exc,
                   mon_exp.pc, mon_exp.nxt, mon_exp.i0, mon_exp.i1,
                   mon_exp.fij, mon_exp.u0, mon_exp.u1, mon_exp.exc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // drain the pipe with full, then flush to t; scoreboard armed after
  task automatic redirect_to(input logic [31:0] t);
    strict = 0;
    @(posedge clk); #1 full = 1;
    repeat (6) @(posedge clk);
    #1 full = 0; flush = 1; flush_target = t; fcyc = cyc;
    @(posedge clk); #1 flush = 0;
    exp_q.delete(); times.delete(); acc_q.delete();
    strict = 1;
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); k++;
    end
    strict = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d packets missing, required 0", nm, exp_q.size());
    end
    #1;
  endtask

  task automatic wait_accept(input string nm);
    int k;
    k = 0;
    while (acc_q.size() == 0 && k < 20) begin
      @(posedge clk); #1 k++;
    end
    n_chk++;
    if (acc_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no request accepted, required 1", nm);
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{start: 32'h1c00_0000, lat: 1, n: 3, first_next: 32'h1c00_0008};
    vecs[1] = '{start: 32'h1c00_0004, lat: 2, n: 3, first_next: 32'h1c00_0008};
    vecs[2] = '{start: 32'hffff_fff0, lat: 1, n: 4, first_next: 32'hffff_fff8};
    vecs[3] = '{start: 32'h1c00_0ff8, lat: 4, n: 2, first_next: 32'h1c00_1000};

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", icache_req, 0);
    chk("rst_valid", input_valid, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_bpu_pc", bpu_pc, 32'h1c00_0000);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_exc", exception_out, 0);
    chk("rst_inst0", inst0, 0);
    chk("rst_valid_after", input_valid, 0);
    chk("rst_addr", icache_addr, 32'h1c00_0000);

    // straight-line fetch table
    foreach (vecs[i]) begin
      logic [31:0] p, nx;
      int n;
      n = vecs[i].n;
      lat = vecs[i].lat;
      redirect_to(vecs[i].start);
      p = vecs[i].start;
      nx = vecs[i].first_next;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk(p, nx, 1'b0));
        p = nx;
        nx = nx + 32'd8;
      end
      drain("vec_drain", 80);
      if (times.size() >= n) begin
        chk("vec_first_latency", times[0], fcyc + 2 + lat);
        chk("vec_period", times[n-1] - times[0], lat * (n - 1));
      end else begin
        chk("vec_pkt_count", times.size(), n);
      end
    end

    // predicted taken jump
    lat = 1;
    jmp_src = 32'h1c00_0000;
    jmp_dst = 32'h1c00_0104;
    redirect_to(32'h1c00_0000);
    exp_q.push_back(mk(32'h1c00_0000, 32'h1c00_0104, 1'b1));
    exp_q.push_back(mk(32'h1c00_0104, 32'h1c00_0108, 1'b0));
    exp_q.push_back(mk(32'h1c00_0108, 32'h1c00_0110, 1'b0));
    drain("jmp_drain", 40);
    if (acc_q.size() >= 2) chk("jmp_addr", acc_q[1], 32'h1c00_0100);
    else chk("jmp_acc_count", acc_q.size(), 2);
    jmp_src = 32'hffff_ffff;

    // flush while a request is outstanding
    lat = 3;
    redirect_to(32'h1c00_0100);
    wait_accept("flushw_accept");
    strict = 0;
    flush = 1; flush_target = 32'h1c00_0200;
    @(posedge clk); #1 flush = 0;
    acc_q.delete(); exp_q.delete(); times.delete();
    exp_q.push_back(mk(32'h1c00_0200, 32'h1c00_0208, 1'b0));
    exp_q.push_back(mk(32'h1c00_0208, 32'h1c00_0210, 1'b0));
    strict = 1;
    drain("flushw_drain", 40);
    if (acc_q.size() >= 1) chk("flushw_addr", acc_q[0], 32'h1c00_0200);
    else chk("flushw_acc_count", acc_q.size(), 1);

    // set_pc alongside a valid packet
    lat = 1;
    redirect_to(32'h1c00_0000);
    strict = 0;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk); #1 k++;
      end while (!input_valid && k < 20);
      chk("setpc_saw_pkt", input_valid, 1);
    end
    set_pc = 1; set_pc_target = 32'h1c00_0080;
    #1 chk("setpc_no_req", icache_req, 0);
    @(posedge clk); #1 set_pc = 0;
    exp_q.delete(); times.delete();
    exp_q.push_back(mk(32'h1c00_0080, 32'h1c00_0088, 1'b0));
    exp_q.push_back(mk(32'h1c00_0088, 32'h1c00_0090, 1'b0));
    strict = 1;
    drain("setpc_drain", 40);

    // full held for 5 cycles with a request outstanding
    lat = 3;
    redirect_to(32'h1c00_0300);
    exp_q.push_back(mk(32'h1c00_0300, 32'h1c00_0308, 1'b0));
    exp_q.push_back(mk(32'h1c00_0308, 32'h1c00_0310, 1'b0));
    exp_q.push_back(mk(32'h1c00_0310, 32'h1c00_0318, 1'b0));
    wait_accept("full_accept");
    full = 1;
    repeat (5) begin
      @(negedge clk);
      chk("full_no_req", icache_req, 0);
    end
    @(posedge clk); #1 full = 0;
    chk("full_outstanding_left", exp_q.size(), 2);
    drain("full_drain", 40);

    // misaligned flush target
    lat = 1;
    redirect_to(32'h1c00_0002);
    exp_q.push_back('{pc: 32'h1c00_0002, nxt: 32'h1c00_0006,
                      i0: NOP, i1: NOP, fij: 0, u0: 0, u1: 0, exc: ADEF});
    drain("adef_drain", 20);
    repeat (8) begin
      @(negedge clk);
      chk("adef_hold_no_req", icache_req, 0);
    end
    redirect_to(32'h1c00_0000);
    exp_q.push_back(mk(32'h1c00_0000, 32'h1c00_0008, 1'b0));
    drain("adef_resume", 20);

    // i-cache fetch exception
    exc_addr = 32'h1c00_0408;
    redirect_to(32'h1c00_0400);
    exp_q.push_back(mk(32'h1c00_0400, 32'h1c00_0408, 1'b0));
    exp_q.push_back('{pc: 32'h1c00_0408, nxt: 32'h1c00_0410,
                      i0: NOP, i1: NOP, fij: 0, u0: 1, u1: 0, exc: IEXC});
    drain("iexc_drain", 20);
    repeat (5) begin
      @(negedge clk);
      chk("iexc_hold_no_req", icache_req, 0);
    end
    exc_addr = 32'hffff_ffff;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage, the producer end of the decode stage's fetch-packet interface. It owns the fetch PC, issues one aligned 8-byte request at a time to the i-cache, samples the branch predictor at issue, and delivers one registered two-instruction packet per response. Redirects come from the back-end (`flush`) and from the decoder's predecode correction (`set_pc`). Fetch is throttled by the decoder's `full`.

## Interface
- `RESET_PC`, default 32'h1c000000: PC loaded at reset.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  back-end redirect; highest priority
- `flush_target`  in  32  PC after flush
- `set_pc`  in  1  decoder predecode redirect; only honoured while `input_valid` is high
- `set_pc_target`  in  32  PC after set_pc
- `full`  in  1  decoder fetch-buffer near-full; blocks new requests
- `bpu_pc`  out  32  current fetch PC presented to predictor (= pc register)
- `bpu_pc_next`  in  32  predicted PC following this packet
- `bpu_first_inst_jmp`, `bpu_unknown0`, `bpu_unknown1`  in  1 each  predictor attributes for `bpu_pc`
- `icache_req`  out  1  request valid
- `icache_addr`  out  32  `{pc[31:3],3'b0}`
- `icache_addr_ok`  in  1  request accepted this cycle
- `icache_data_valid`  in  1  response for oldest accepted request
- `icache_rdata`  in  64  [31:0] word at addr, [63:32] word at addr+4
- `icache_exception`  in  7  fetch exception (exception.vh encoding), valid with data
- `input_valid`  out  1  packet valid, one cycle per packet
- `inst0`, `inst1`  out  32 each  instructions; `INST_NOP` when exception
- `pc_out`, `pc_next_out`  out  32 each  packet PC (unaligned as fetched) and predicted next PC
- `first_inst_jmp`, `unknown0`, `unknown1`  out  1 each  registered predictor attributes
- `exception_out`  out  7  packet exception, 0 if none

## Operation
- States: RUN (no request outstanding), WAIT (one accepted, live), DROP (one accepted, killed), HOLD (exception packet sent, waiting for flush).
- RUN: `icache_req = ~full & ~flush & ~(input_valid & set_pc) & pc[1:0]==0`. On `icache_addr_ok`: latch pc and predictor inputs into meta regs, pc <= `bpu_pc_next`, go WAIT.
- RUN with `pc[1:0]!=0` and `~full`: no request; next cycle emit packet with `exception_out=EXP_ADEF`, NOPs, `pc_out=pc`, `pc_next_out=pc+4`; go HOLD.
- WAIT on `icache_data_valid`: next cycle emit packet from rdata + meta regs; `exception_out=icache_exception`, NOPs if nonzero, then HOLD. Otherwise the same cycle may issue the next request (back-to-back, stays WAIT), else RUN.
- DROP on `icache_data_valid`: discard data, no packet, go RUN (request may issue the same cycle).
- Redirect (`flush`, or `set_pc & input_valid`): pc <= target; WAIT->DROP, DROP stays DROP, HOLD/RUN->RUN; any response in that cycle is discarded; no request issued that cycle. flush beats set_pc.
- HOLD leaves only via flush or rst.
- `full` never cancels an outstanding request; the decoder reserves 2 entries for it.

## Timing
- Reset: state RUN, pc=RESET_PC, `input_valid=0`, `icache_req=0`, all packet outputs 0.
- Latency: accept in cycle N, data in N+k (k>=1), `input_valid` in N+k+1, registered.
- Max throughput: one packet per cycle when i-cache returns data in the cycle after accept.
- rst mid-WAIT: state RUN; a late response (i-cache reset with same `rst`) is not expected.
- pc arithmetic mod 2^32; `pc_next_out` = latched `bpu_pc_next` verbatim.

## Structure
- `EXP_ADEF` and the 7-bit exception encoding come from exception.vh; `INST_NOP` from uop.vh. Add `IF_RUN/IF_WAIT/IF_DROP/IF_HOLD` localparams in the module.
- No sub-module; single FSM plus pc/meta registers.

## Test plan
- Reset, i-cache 1-cycle, predictor pc+8: packets at 1c000000, 1c000008, 1c000010 on consecutive cycles, `pc_next_out` = pc+8.
- Predictor `bpu_pc_next=1c000104` with first_inst_jmp at 1c000000: packet `pc_out=1c000000,first_inst_jmp=1`; next request addr 1c000100, `pc_out=1c000104`.
- flush to 1c000200 while WAIT: response discarded, no packet, next request addr 1c000200.
- set_pc to 1c000080 with `input_valid`: no request that cycle, outstanding response dropped, next packet `pc_out=1c000080`.
- `full` held 5 cycles: `icache_req=0` throughout, outstanding response still delivered, fetch resumes after deassert.
- flush to 1c000002: `exception_out=EXP_ADEF`, inst0/inst1=NOP, no `icache_req` until flush to 1c000000.
